// File: rtl/d_sram_bridge.sv
// d_sram_bridge: turns a core memory-stage access into one SRAM-like bus transaction.
// The bridge freezes the pipeline while the transaction is outstanding and returns
// the load data once it has been captured.
//
// Ports
//   clk, rst        : clock (rising edge) and asynchronous active-high reset
//   mem_ce          : access request from the memory stage
//   memwriteM       : 1 = store, 0 = load
//   mem_sel[3:0]    : byte lanes, decoded into the bus transfer size
//   aluoutM         : access address
//   writedataM      : store data
//   cpu_longstall   : pipeline frozen by another source; holds the bridge in DONE
//   readdataM       : load data (read register)
//   mem_stall       : combinational pipeline freeze request
//   data_req/wr/size/addr/wdata : bus request channel
//   data_addr_ok    : bus accepted the request
//   data_data_ok    : bus returned data / completed the write
//   data_rdata      : bus read data
module d_sram_bridge #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // core side
    input  logic              mem_ce,
    input  logic              memwriteM,
    input  logic [3:0]        mem_sel,
    input  logic [ADDR_W-1:0] aluoutM,
    input  logic [31:0]       writedataM,
    input  logic              cpu_longstall,
    output logic [31:0]       readdataM,
    output logic              mem_stall,
    // bus side
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              wr_q,    wr_d;
    logic [1:0]        size_q,  size_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [1:0]        size_dec;

    // Byte-lane pattern to transfer size; unrecognised patterns fall back to a word.
    always_comb begin
        size_dec = 2'd2;
        unique case (mem_sel)
            4'b1111:                            size_dec = 2'd2;
            4'b0011, 4'b1100:                   size_dec = 2'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size_dec = 2'd0;
            default:                            size_dec = 2'd2;
        endcase
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        size_d  = size_q;
        rdata_d = rdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (mem_ce) begin
                    addr_d  = aluoutM;
                    wdata_d = writedataM;
                    wr_d    = memwriteM;
                    size_d  = size_dec;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // data_ok is only meaningful once the address has been accepted.
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        rdata_d = data_rdata;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (data_data_ok) begin
                    rdata_d = data_rdata;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Stay here while the core is frozen so the access is not reissued.
                if (!cpu_longstall) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and payload registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            rdata_q <= rdata_d;
        end
    end

    // Stall covers the detect cycle in IDLE so the core never advances past an access.
    assign mem_stall = ((state_q == S_IDLE) && mem_ce) ||
                       (state_q == S_REQ) ||
                       (state_q == S_WAIT);

    assign data_req   = (state_q == S_REQ);
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;
    assign readdataM  = rdata_q;

endmodule

// File: tb/tb_d_sram_bridge.sv
// Directed bench for d_sram_bridge: load, delayed store, coincident accept,
// size decode, longstall hold and reset in the middle of a transaction.
module tb_d_sram_bridge;

    logic        clk;
    logic        rst;
    logic        mem_ce;
    logic        memwriteM;
    logic [3:0]  mem_sel;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic        cpu_longstall;
    logic [31:0] readdataM;
    logic        mem_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int checks = 0;
    int errors = 0;
    int txn_cnt = 0;
    int txn0;
    int reqcnt;

    d_sram_bridge #(.ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_ce        (mem_ce),
        .memwriteM     (memwriteM),
        .mem_sel       (mem_sel),
        .aluoutM       (aluoutM),
        .writedataM    (writedataM),
        .cpu_longstall (cpu_longstall),
        .readdataM     (readdataM),
        .mem_stall     (mem_stall),
        .data_req      (data_req),
        .data_wr       (data_wr),
        .data_size     (data_size),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_addr_ok  (data_addr_ok),
        .data_data_ok  (data_data_ok),
        .data_rdata    (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accepted requests seen on the bus.
    always @(posedge clk) begin
        if (!rst && data_req && data_addr_ok) txn_cnt <= txn_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One coincident-accept load used to exercise the size decode.
    task automatic quick(input string tag, input logic [3:0] sel, input logic [1:0] exp_size,
                         input logic [31:0] rd);
        mem_ce = 1'b1; memwriteM = 1'b0; mem_sel = sel; aluoutM = 32'h5000_0000;
        #1;
        chk({tag, "_stall"}, 32'(mem_stall), 32'd1);
        tick();
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = rd;
        #1;
        chk({tag, "_size"}, 32'(data_size), 32'(exp_size));
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b0; mem_ce = 1'b0;
        #1;
        chk({tag, "_rdata"}, readdataM, rd);
        tick();
    endtask

    initial begin
        rst = 1'b1; mem_ce = 1'b0; memwriteM = 1'b0; mem_sel = 4'h0; aluoutM = '0;
        writedataM = '0; cpu_longstall = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        data_rdata = '0;
        #3;
        chk("rst_req",   32'(data_req),  32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_rdata", readdataM,      32'd0);
        chk("rst_wr",    32'(data_wr),   32'd0);
        chk("rst_size",  32'(data_size), 32'd0);
        chk("rst_addr",  data_addr,      32'd0);
        chk("rst_wdata", data_wdata,     32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Zero-wait word load.
        mem_ce = 1'b1; memwriteM = 1'b0; mem_sel = 4'b1111; aluoutM = 32'h1000_0004;
        #1;
        chk("ld_detect_stall", 32'(mem_stall), 32'd1);
        chk("ld_detect_req",   32'(data_req),  32'd0);
        tick();
        data_addr_ok = 1'b1;
        #1;
        chk("ld_req_req",   32'(data_req),  32'd1);
        chk("ld_req_stall", 32'(mem_stall), 32'd1);
        chk("ld_req_size",  32'(data_size), 32'd2);
        chk("ld_req_addr",  data_addr,      32'h1000_0004);
        chk("ld_req_wr",    32'(data_wr),   32'd0);
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        #1;
        chk("ld_wait_req",   32'(data_req),  32'd0);
        chk("ld_wait_stall", 32'(mem_stall), 32'd1);
        tick();
        data_data_ok = 1'b0; data_rdata = 32'h0; mem_ce = 1'b0;
        #1;
        chk("ld_done_stall", 32'(mem_stall), 32'd0);
        chk("ld_done_rdata", readdataM,      32'hDEAD_BEEF);
        tick();
        chk("ld_idle_req",   32'(data_req),  32'd0);
        chk("ld_idle_rdata", readdataM,      32'hDEAD_BEEF);

        // Byte store with addr_ok delayed four cycles; an early data_ok must be ignored.
        mem_ce = 1'b1; memwriteM = 1'b1; mem_sel = 4'b0100; aluoutM = 32'h2000_0002;
        writedataM = 32'h00AB_0000;
        #1;
        chk("st_detect_stall", 32'(mem_stall), 32'd1);
        reqcnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            data_addr_ok = (i == 4);
            data_data_ok = (i == 2);
            data_rdata   = 32'h1111_1111;
            #1;
            if (data_req) reqcnt++;
            chk("st_req_req",   32'(data_req),  32'd1);
            chk("st_req_wr",    32'(data_wr),   32'd1);
            chk("st_req_size",  32'(data_size), 32'd0);
            chk("st_req_addr",  data_addr,      32'h2000_0002);
            chk("st_req_wdata", data_wdata,     32'h00AB_0000);
        end
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0000_0055;
        #1;
        chk("st_wait_req",   32'(data_req),  32'd0);
        chk("st_wait_stall", 32'(mem_stall), 32'd1);
        chk("st_wait_addr",  data_addr,      32'h2000_0002);
        chk("st_wait_wdata", data_wdata,     32'h00AB_0000);
        chk("st_req_cycles", 32'(reqcnt),    32'd5);
        tick();
        data_data_ok = 1'b0; mem_ce = 1'b0; memwriteM = 1'b0;
        #1;
        chk("st_done_stall", 32'(mem_stall), 32'd0);
        tick();

        // Coincident addr_ok/data_ok: WAIT skipped, two stall cycles.
        mem_ce = 1'b1; mem_sel = 4'b0011; aluoutM = 32'h3000_0000;
        #1;
        chk("co_detect_stall", 32'(mem_stall), 32'd1);
        tick();
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
        #1;
        chk("co_req_req",   32'(data_req),  32'd1);
        chk("co_req_stall", 32'(mem_stall), 32'd1);
        chk("co_req_size",  32'(data_size), 32'd1);
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b0; mem_ce = 1'b0;
        #1;
        chk("co_done_stall", 32'(mem_stall), 32'd0);
        chk("co_done_rdata", readdataM,      32'h1234_5678);
        tick();

        // Remaining size-decode patterns.
        quick("sz_1100", 4'b1100, 2'd1, 32'hA5A5_0001);
        quick("sz_0001", 4'b0001, 2'd0, 32'hA5A5_0002);
        quick("sz_0101", 4'b0101, 2'd2, 32'hA5A5_0003);
        quick("sz_0000", 4'b0000, 2'd2, 32'hA5A5_0004);

        // Longstall holds DONE with mem_ce still asserted; a stray data_ok is ignored.
        txn0 = txn_cnt;
        mem_ce = 1'b1; mem_sel = 4'b1000; aluoutM = 32'h1000_0010;
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            cpu_longstall = 1'b1;
            data_data_ok  = (i == 2);
            data_rdata    = 32'hFFFF_FFFF;
            #1;
            chk("ls_stall", 32'(mem_stall), 32'd0);
            chk("ls_req",   32'(data_req),  32'd0);
            chk("ls_rdata", readdataM,      32'hCAFE_F00D);
        end
        tick();
        cpu_longstall = 1'b0; data_data_ok = 1'b0;
        #1;
        chk("ls_rel_stall", 32'(mem_stall), 32'd0);
        chk("ls_rel_req",   32'(data_req),  32'd0);
        tick();
        mem_ce = 1'b0;
        #1;
        chk("ls_idle_stall", 32'(mem_stall), 32'd0);
        chk("ls_idle_rdata", readdataM,      32'hCAFE_F00D);
        chk("ls_txn_count",  32'(txn_cnt - txn0), 32'd1);
        tick();

        // Reset while waiting for data; late data_ok after release must not be captured.
        mem_ce = 1'b1; memwriteM = 1'b0; mem_sel = 4'b1110; aluoutM = 32'h4000_0008;
        writedataM = 32'h0000_0077;
        #1;
        chk("rw_detect_stall", 32'(mem_stall), 32'd1);
        tick();
        data_addr_ok = 1'b1;
        #1;
        chk("rw_req_size", 32'(data_size), 32'd2);
        tick();
        data_addr_ok = 1'b0;
        #1;
        chk("rw_wait_stall", 32'(mem_stall), 32'd1);
        chk("rw_wait_req",   32'(data_req),  32'd0);
        rst = 1'b1; mem_ce = 1'b0;
        #1;
        chk("rw_rst_req",   32'(data_req),  32'd0);
        chk("rw_rst_stall", 32'(mem_stall), 32'd0);
        chk("rw_rst_rdata", readdataM,      32'd0);
        chk("rw_rst_size",  32'(data_size), 32'd0);
        chk("rw_rst_addr",  data_addr,      32'd0);
        chk("rw_rst_wdata", data_wdata,     32'd0);
        tick();
        rst = 1'b0;
        tick();
        data_data_ok = 1'b1; data_rdata = 32'hBAD0_BAD0;
        #1;
        chk("rw_late_stall", 32'(mem_stall), 32'd0);
        tick();
        data_data_ok = 1'b0;
        #1;
        chk("rw_late_rdata", readdataM,      32'd0);
        chk("rw_late_req",   32'(data_req),  32'd0);
        chk("rw_late_stall2", 32'(mem_stall), 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/d_sram_bridge.md
D_SRAM_BRIDGE -- requirements
Module: d_sram_bridge

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the width of the core-side and bus-side data address.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 The block SHALL have core-side inputs, all driven by the core's memory stage:
- mem_ce, 1: access request.
- memwriteM, 1: 1 = store.
- mem_sel, 4: byte lanes.
- aluoutM, ADDR_W: address.
- writedataM, 32: store data.
- cpu_longstall, 1: whole pipeline frozen by another source.
REQ-005 The block SHALL have core-side outputs:
- readdataM, 32: load data.
- mem_stall, 1: freeze the pipeline.
REQ-006 The block SHALL have bus-side outputs:
- data_req, 1
- data_wr, 1
- data_size, 2
- data_addr, ADDR_W
- data_wdata, 32
REQ-007 The block SHALL have bus-side inputs:
- data_addr_ok, 1
- data_data_ok, 1
- data_rdata, 32

Function
REQ-008 The block SHALL implement a 4-state FSM: IDLE, REQ, WAIT, DONE.
REQ-009 IDLE with mem_ce=1 SHALL latch aluoutM, writedataM, memwriteM and the decoded size, then go to REQ next edge; with mem_ce=0 it SHALL stay in IDLE.
REQ-010 Size decode SHALL be: mem_sel 1111 -> 2; 0011 or 1100 -> 1; exactly one bit set -> 0; any other value -> 2.
REQ-011 data_req SHALL be 1 only in REQ; data_wr, data_size, data_addr and data_wdata SHALL come from the latched registers and stay constant from REQ entry until leaving WAIT.
REQ-012 REQ with data_addr_ok=1 and data_data_ok=0 SHALL go to WAIT; with both 1 in the same cycle it SHALL go directly to DONE and capture data_rdata.
REQ-013 REQ with data_addr_ok=0 SHALL hold REQ with the request unchanged, with no timeout.
REQ-014 WAIT with data_data_ok=1 SHALL capture data_rdata into the read register and go to DONE.
REQ-015 Any data_data_ok arriving in IDLE, REQ (before addr_ok) or DONE SHALL be ignored.
REQ-016 mem_stall SHALL be combinational: 1 when (state=IDLE and mem_ce=1), or state=REQ, or state=WAIT; 0 otherwise.
REQ-017 Stall SHALL be 1 in the data_data_ok cycle and SHALL drop to 0 in the first DONE cycle.
REQ-018 readdataM SHALL always drive the read register; for stores the register is still loaded from data_rdata and the value is don't-care to the core.
REQ-019 DONE with cpu_longstall=0 SHALL go to IDLE; with cpu_longstall=1 it SHALL stay in DONE without reissuing, keeping readdataM stable.
REQ-020 Minimum load latency SHALL be 3 cycles of stall with zero-wait bus (detect, REQ, WAIT), or 2 cycles if addr_ok and data_ok coincide.
REQ-021 Exactly one bus transaction SHALL be issued per memory-stage instruction; back-to-back accesses SHALL pass through DONE then IDLE, giving at least one non-stalled cycle between them.

Reset
REQ-022 Asserting rst at any time SHALL immediately force IDLE with data_req=0, and SHALL clear to 0: mem_stall (when mem_ce=0), readdataM, data_wr, data_size, data_addr and data_wdata.
REQ-023 Reset during REQ or WAIT SHALL abandon the transaction; late data_ok after release is ignored per REQ-015.

Verification
REQ-024 Load, zero-wait: aluoutM=0x1000_0004, mem_sel=1111, memwriteM=0, addr_ok=1 in REQ, data_ok=1 next cycle with rdata=0xDEADBEEF -> data_size=2, mem_stall high 3 cycles, readdataM=0xDEADBEEF in DONE.
REQ-025 Byte store: mem_sel=0100, writedataM=0x00AB0000, addr_ok delayed 4 cycles -> data_req held 4+1 cycles, data_wr=1, data_size=0, data_addr/data_wdata constant throughout.
REQ-026 Coincident accept: addr_ok=1 and data_ok=1 in the same REQ cycle, rdata=0x12345678 -> WAIT skipped, stall 2 cycles, readdataM=0x12345678.
REQ-027 Longstall: cpu_longstall=1 for 5 cycles after DONE entry -> FSM stays in DONE, data_req stays 0, readdataM unchanged, exactly one transaction counted.
REQ-028 Reset mid-WAIT: rst pulse in WAIT, then data_ok=1 after release -> IDLE, data_req=0, readdataM=0, no capture of the late data.
